// File: rtl/fir_out_requant.sv
// ---------------------------------------------------------------------------
// fir_out_requant
//
// Output stage behind the FIR filter. It takes the filter's wide signed
// result stream and processes each sample as follows:
//   1. Rounds each sample half-up and drops SHIFT LSBs.
//   2. Saturates the result to OUT_W signed bits.
//   3. Keeps one of every DECIM valid samples.
//   4. Queues the kept samples in a show-ahead FIFO. The FIFO drives a
//      valid/ready consumer interface.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active low
//   data_in    : IN_W-bit signed sample from the filter
//   valid_in   : qualifies data_in (no backpressure toward the filter)
//   clr_flags  : single-cycle pulse that clears sat_flag and ovf_flag
//   data_out   : OUT_W-bit signed sample at the FIFO head
//   valid_out  : FIFO holds at least one sample
//   ready_out  : consumer takes data_out when valid_out & ready_out
//   fifo_count : current FIFO occupancy
//   sat_flag   : sticky, a kept sample was clamped
//   ovf_flag   : sticky, a kept sample was lost to a full FIFO
// ---------------------------------------------------------------------------
module fir_out_requant #(
  parameter int IN_W       = 36,
  parameter int OUT_W      = 19,
  parameter int SHIFT      = 17,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_W-1:0]               data_in,
  input  logic                          valid_in,
  input  logic                          clr_flags,
  output logic [OUT_W-1:0]              data_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic                          ovf_flag
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);

  // Rounding and clamp constants, all expressed in the IN_W+1 bit
  // arithmetic domain so that adding the rounding half cannot overflow.
  localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = -SAT_MAX - 1;

  // -------------------------------------------------------------------------
  // Requantisation (combinational, registered in stage 1)
  // -------------------------------------------------------------------------
  logic signed [IN_W:0] ext_in;
  logic signed [IN_W:0] rnd_sum;
  logic signed [IN_W:0] rnd_shr;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     req_data;

  assign ext_in  = $signed({data_in[IN_W-1], data_in});
  assign rnd_sum = ext_in + HALF;
  // The arithmetic shift floors, so adding half first gives round-half-up.
  assign rnd_shr = rnd_sum >>> SHIFT;
  assign sat_hi  = (rnd_shr > SAT_MAX);
  assign sat_lo  = (rnd_shr < SAT_MIN);

  always_comb begin
    req_data = rnd_shr[OUT_W-1:0];
    if (sat_hi) begin
      req_data = SAT_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      req_data = SAT_MIN[OUT_W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Decimator
  // -------------------------------------------------------------------------
  logic [PH_W-1:0] phase_reg;
  logic [PH_W-1:0] phase_next;
  logic            keep;

  assign keep = valid_in && (phase_reg == '0);

  always_comb begin
    phase_next = phase_reg;
    if (valid_in) begin
      if (phase_reg == PH_LAST) begin
        phase_next = '0;
      end else begin
        phase_next = phase_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 register: only kept samples become valid here
  // -------------------------------------------------------------------------
  logic             s1_valid_reg;
  logic [OUT_W-1:0] s1_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      phase_reg    <= phase_next;
      s1_valid_reg <= keep;
      if (keep) begin
        s1_data_reg <= req_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO (stage 2 push side, consumer pop side)
  // -------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [OUT_W-1:0] dout_reg;
  logic [OUT_W-1:0] dout_next;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full       = (count_reg == FULL_CNT);
  assign pop        = (count_reg != '0) && ready_out;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push       = s1_valid_reg && (!full || pop);
  assign drop       = s1_valid_reg && full && !pop;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // data_out is a register that is loaded with the next head word. When the
  // FIFO drains, it keeps the last popped value. When the next head is the
  // word being pushed right now, that word bypasses the memory.
  always_comb begin
    dout_next = dout_reg;
    if (count_next != '0) begin
      if (pop) begin
        if (count_reg == CNT_W'(1)) begin
          dout_next = s1_data_reg;
        end else begin
          dout_next = mem[rd_ptr_inc];
        end
      end else if (count_reg == '0) begin
        dout_next = s1_data_reg;
      end
    end
  end

  // Storage array has no reset; the occupancy count qualifies its contents.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg] <= s1_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_next;
      dout_reg  <= dout_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky flags; setting wins over a simultaneous clear
  // -------------------------------------------------------------------------
  logic sat_reg;
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      sat_reg <= (keep && (sat_hi || sat_lo)) || (sat_reg && !clr_flags);
      ovf_reg <= drop || (ovf_reg && !clr_flags);
    end
  end

  assign data_out   = dout_reg;
  assign valid_out  = (count_reg != '0);
  assign fifo_count = count_reg;
  assign sat_flag   = sat_reg;
  assign ovf_flag   = ovf_reg;

endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] data_in;
  logic        valid_in;
  logic        clr_flags;
  logic        ready_out;
  logic [18:0] data_out;
  logic        valid_out;
  logic [3:0]  fifo_count;
  logic        sat_flag;
  logic        ovf_flag;

  logic [18:0] d4_data_out;
  logic        d4_valid_out;
  logic [3:0]  d4_fifo_count;
  logic        d4_sat_flag;
  logic        d4_ovf_flag;

  always #5 clk = ~clk;

  fir_out_requant dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .clr_flags(clr_flags), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .fifo_count(fifo_count), .sat_flag(sat_flag),
    .ovf_flag(ovf_flag)
  );

  fir_out_requant #(.DECIM(4)) dut_d4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .clr_flags(clr_flags), .data_out(d4_data_out), .valid_out(d4_valid_out),
    .ready_out(1'b1), .fifo_count(d4_fifo_count), .sat_flag(d4_sat_flag),
    .ovf_flag(d4_ovf_flag)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference requantisation: floor((x + 2^16) / 2^17), clamped to 19-bit signed.
  function automatic logic [18:0] req(input logic [35:0] x, output bit clamped);
    longint v;
    longint r;
    v = longint'($signed(x));
    r = (v + 65536) >>> 17;
    clamped = 0;
    if (r > 262143) begin
      r = 262143;
      clamped = 1;
    end else if (r < -262144) begin
      r = -262144;
      clamped = 1;
    end
    return r[18:0];
  endfunction

  // Model of the DECIM=1 instance: the FIFO content as a queue, plus one pending kept sample.
  logic [18:0] mq[$];
  bit          pend_v;
  logic [18:0] pend_d;
  bit          m_sat;
  bit          m_ovf;
  logic [18:0] m_dout;

  task automatic cycle(input bit rst, input bit vin, input logic [35:0] din,
                       input bit clr, input bit rdy);
    bit          cl;
    bit          ovf_set;
    logic [18:0] v;
    rst_n     = rst;
    valid_in  = vin;
    data_in   = din;
    clr_flags = clr;
    ready_out = rdy;
    if (!rst) begin
      mq.delete();
      pend_v = 0;
      m_sat  = 0;
      m_ovf  = 0;
      m_dout = '0;
    end else begin
      if (mq.size() != 0 && rdy) begin
        $display("pop  data=%05h remaining=%0d", mq[0], mq.size() - 1);
        void'(mq.pop_front());
      end
      ovf_set = 0;
      if (pend_v) begin
        if (mq.size() < 8) mq.push_back(pend_d);
        else ovf_set = 1;
      end
      v      = req(din, cl);
      m_sat  = (vin && cl) || (m_sat && !clr);
      m_ovf  = ovf_set || (m_ovf && !clr);
      pend_v = vin;
      pend_d = v;
      if (mq.size() != 0) m_dout = mq[0];
    end
    @(posedge clk);
    #1;
    check("valid_out", 64'(valid_out), 64'(mq.size() != 0));
    check("data_out", 64'(data_out), 64'(m_dout));
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
    check("sat_flag", 64'(sat_flag), 64'(m_sat));
    check("ovf_flag", 64'(ovf_flag), 64'(m_ovf));
  endtask

  // DECIM=4 instance: every kept sample must come out, in order.
  logic [18:0] q4[$];
  logic [18:0] d4_seen[$];
  int          ph4 = 0;

  always @(posedge clk) begin
    bit c;
    if (!rst_n) begin
      q4.delete();
      ph4 = 0;
    end else if (valid_in) begin
      if (ph4 == 0) q4.push_back(req(data_in, c));
      ph4 = (ph4 == 3) ? 0 : ph4 + 1;
    end
  end

  always @(negedge clk) begin
    if (d4_valid_out === 1'b1) begin
      if (q4.size() == 0) begin
        check("d4_valid_out", 64'(d4_valid_out), 64'(0));
      end else begin
        check("d4_data_out", 64'(d4_data_out), 64'(q4[0]));
        $display("d4   data=%05h", d4_data_out);
        d4_seen.push_back(d4_data_out);
        void'(q4.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [35:0] t2_in  [4];
  logic [18:0] t2_exp [4];
  logic [18:0] t4_exp [3];
  logic [35:0] rnd;

  initial begin
    t2_in  = '{36'h0_0002_0000, 36'h0_0001_0000, 36'hF_FFFF_0000, 36'hF_FFFE_FFFF};
    t2_exp = '{19'h00001, 19'h00001, 19'h00000, 19'h7FFFF};
    t4_exp = '{19'd1, 19'd5, 19'd9};
    rst_n = 0; valid_in = 0; data_in = '0; clr_flags = 0; ready_out = 0;

    // 1: reset with valid_in high, then latency
    repeat (3) cycle(0, 1, {4'h0, $urandom}, 0, 1);
    check("t1_count", 64'(fifo_count), 64'(0));
    cycle(1, 1, 36'h0_0002_0000, 0, 1);
    check("t1_lat1", 64'(valid_out), 64'(0));
    cycle(1, 0, '0, 0, 1);
    check("t1_lat2", 64'(valid_out), 64'(1));
    check("t1_data", 64'(data_out), 64'(1));

    // 2: rounding
    for (int i = 0; i < 5; i++) begin
      cycle(1, i < 4, (i < 4) ? t2_in[i] : 36'h0, 0, 1);
      if (i >= 1) check("t2_round", 64'(data_out), 64'(t2_exp[i-1]));
    end
    check("t2_sat", 64'(sat_flag), 64'(0));

    // 3: saturation and flag clear
    cycle(1, 1, 36'h7_FFFF_FFFF, 0, 1);
    cycle(1, 1, 36'h8_0000_0000, 0, 1);
    check("t3_pos", 64'(data_out), 64'(19'h3FFFF));
    cycle(1, 0, '0, 0, 1);
    check("t3_neg", 64'(data_out), 64'(19'h40000));
    check("t3_sat", 64'(sat_flag), 64'(1));
    cycle(1, 0, '0, 1, 1);
    check("t3_clr", 64'(sat_flag), 64'(0));

    // 4: decimation by 4 on the second instance
    cycle(0, 0, '0, 0, 1);
    d4_seen.delete();
    for (int k = 1; k <= 12; k++) cycle(1, 1, 36'(k) << 17, 0, 1);
    repeat (3) cycle(1, 0, '0, 0, 1);
    check("t4_n", 64'(d4_seen.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      if (i < d4_seen.size()) check("t4_val", 64'(d4_seen[i]), 64'(t4_exp[i]));
    check("t4_ovf", 64'(d4_ovf_flag), 64'(0));

    // 5: overflow, then ordered drain
    cycle(0, 0, '0, 0, 0);
    for (int k = 1; k <= 10; k++) cycle(1, 1, 36'(k) << 17, 0, 0);
    cycle(1, 0, '0, 0, 0);
    check("t5_full", 64'(fifo_count), 64'(8));
    check("t5_ovf", 64'(ovf_flag), 64'(1));
    for (int k = 1; k <= 8; k++) begin
      check("t5_head", 64'(data_out), 64'(k));
      cycle(1, 0, '0, 0, 1);
    end
    check("t5_empty", 64'(valid_out), 64'(0));
    check("t5_hold", 64'(data_out), 64'(8));

    // 6: push and pop on a full FIFO, then reset mid-drain
    cycle(0, 0, '0, 0, 0);
    for (int k = 1; k <= 9; k++) cycle(1, 1, 36'(k + 20) << 17, 0, 0);
    check("t6_full", 64'(fifo_count), 64'(8));
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 1, 36'(k + 40) << 17, 0, 1);
      check("t6_count", 64'(fifo_count), 64'(8));
    end
    check("t6_ovf", 64'(ovf_flag), 64'(0));
    cycle(0, 1, '0, 0, 1);
    check("t6_rst_valid", 64'(valid_out), 64'(0));
    check("t6_rst_count", 64'(fifo_count), 64'(0));

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) rnd = {4'($urandom_range(15)), $urandom};
      else rnd = 36'($signed($urandom) >>> $urandom_range(12));
      cycle($urandom_range(99) != 0, $urandom_range(9) < 7, rnd,
            $urandom_range(19) == 0, $urandom_range(9) < 6);
    end
    repeat (12) cycle(1, 0, '0, 0, 1);
    check("d4_drained", 64'(q4.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
